// File: rtl/prng8check_if.sv
// rtl/prng8check_if.sv - byte stream and status bundle for the PRNG receive checker
interface prng8check_if #(
    parameter int CNT_W = 16
) ();
    logic             update;
    logic [7:0]       data;
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] err_count;
    logic [7:0]       expected;

    modport master (
        output update, data,
        input  locked, error, err_count, expected
    );

    modport slave (
        input  update, data,
        output locked, error, err_count, expected
    );
endinterface

// File: rtl/prng8check.sv
// rtl/prng8check.sv - self-synchronising checker for the parallel 8-bit PRNG byte stream
module prng8check #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         Rst,
    prng8check_if.slave  bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t           r_state, w_state_nx;
    logic [7:0]       r_expected, w_expected_nx;
    logic [MW-1:0]    r_match_cnt, w_match_nx;
    logic [BW-1:0]    r_bad_cnt, w_bad_nx;
    logic [CNT_W-1:0] r_err_count, w_err_count_nx;
    logic             r_error, w_error_nx;
    logic             r_locked;
    logic [7:0]       w_f_data;
    logic [7:0]       w_f_expected;
    logic             w_hit;

    // Eight single LFSR steps, x^8+x^6+x^5+x^4+1, matching the parallel generator.
    function automatic logic [7:0] lfsr_f(input logic [7:0] x);
        logic [7:0] s;
        s = x;
        for (int i = 0; i < 8; i++) begin
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        return s;
    endfunction

    assign w_f_data     = lfsr_f(bus.data);
    assign w_f_expected = lfsr_f(r_expected);
    assign w_hit        = (bus.data == r_expected);

    always_comb begin
        w_state_nx     = r_state;
        w_expected_nx  = r_expected;
        w_match_nx     = r_match_cnt;
        w_bad_nx       = r_bad_cnt;
        w_err_count_nx = r_err_count;
        w_error_nx     = 1'b0;
        if (bus.update) begin
            case (r_state)
                ST_SEARCH: begin
                    if (bus.data != 8'h00) begin
                        w_expected_nx = w_f_data;
                        w_match_nx    = '0;
                        w_state_nx    = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (w_hit) begin
                        w_expected_nx = w_f_data;
                        w_match_nx    = r_match_cnt + 1'b1;
                        if (w_match_nx == MW'(LOCK_CNT)) begin
                            w_state_nx = ST_LOCKED;
                            w_bad_nx   = '0;
                        end
                    end else if (bus.data != 8'h00) begin
                        w_expected_nx = w_f_data;
                        w_match_nx    = '0;
                    end else begin
                        w_match_nx = '0;
                        w_state_nx = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    // Free-run so a corrupted byte never poisons the prediction.
                    w_expected_nx = w_f_expected;
                    if (w_hit) begin
                        w_bad_nx = '0;
                    end else begin
                        w_error_nx = 1'b1;
                        if (r_err_count != '1) begin
                            w_err_count_nx = r_err_count + 1'b1;
                        end
                        w_bad_nx = r_bad_cnt + 1'b1;
                        if (w_bad_nx == BW'(LOSS_CNT)) begin
                            w_state_nx = ST_SEARCH;
                            w_match_nx = '0;
                        end
                    end
                end
                default: w_state_nx = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state     <= ST_SEARCH;
            r_expected  <= 8'h00;
            r_match_cnt <= '0;
            r_bad_cnt   <= '0;
            r_err_count <= '0;
            r_error     <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_expected  <= w_expected_nx;
            r_match_cnt <= w_match_nx;
            r_bad_cnt   <= w_bad_nx;
            r_err_count <= w_err_count_nx;
            r_error     <= w_error_nx;
            r_locked    <= (w_state_nx == ST_LOCKED);
        end
    end

    assign bus.locked    = r_locked;
    assign bus.error     = r_error;
    assign bus.err_count = r_err_count;
    assign bus.expected  = r_expected;
endmodule

// File: tb/tb_prng8check.sv
// tb/tb_prng8check.sv - randomized model-checked bench for prng8check
module tb_prng8check;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 4;

    logic clk = 1'b0;
    logic Rst;
    always #5 clk = ~clk;

    prng8check_if #(.CNT_W(16)) bus_a ();
    prng8check_if #(.CNT_W(2))  bus_b ();

    prng8check #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(16)) u_dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus_a)
    );

    prng8check #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(2)) u_sat (
        .clk (clk),
        .Rst (Rst),
        .bus (bus_b)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: 0 = hunting, 1 = confirming, 2 = locked.
    int         m_mode;
    logic [7:0] m_pred;
    int         m_run;
    int         m_bad;
    int         m_errc16;
    int         m_errc2;
    bit         m_err;
    logic [7:0] g;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_f(input logic [7:0] x);
        logic [7:0] s;
        s = x;
        repeat (8) s = (s << 1) | {7'd0, ^(s & 8'hB8)};
        return s;
    endfunction

    task automatic model_update(input bit rst, input bit upd, input logic [7:0] d);
        bit hit;
        m_err = 1'b0;
        if (rst) begin
            m_mode = 0; m_pred = 8'h00; m_run = 0; m_bad = 0; m_errc16 = 0; m_errc2 = 0;
        end else if (upd) begin
            hit = (d == m_pred);
            if (m_mode == 0) begin
                if (d != 0) begin m_pred = ref_f(d); m_run = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (hit) begin
                    m_pred = ref_f(d);
                    m_run++;
                    if (m_run == LOCK_CNT) begin m_mode = 2; m_bad = 0; end
                end else if (d != 0) begin
                    m_pred = ref_f(d); m_run = 0;
                end else begin
                    m_mode = 0; m_run = 0;
                end
            end else begin
                m_pred = ref_f(m_pred);
                if (hit) m_bad = 0;
                else begin
                    m_err = 1'b1;
                    if (m_errc16 < 65535) m_errc16++;
                    if (m_errc2 < 3) m_errc2++;
                    m_bad++;
                    if (m_bad == LOSS_CNT) begin m_mode = 0; m_run = 0; end
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit upd, input logic [7:0] d);
        Rst = rst;
        bus_a.update = upd; bus_a.data = d;
        bus_b.update = upd; bus_b.data = d;
        @(posedge clk);
        #1;
        model_update(rst, upd, d);
        check("locked",        32'(bus_a.locked),    32'(m_mode == 2));
        check("error",         32'(bus_a.error),     32'(m_err));
        check("err_count",     32'(bus_a.err_count), 32'(m_errc16));
        check("expected",      32'(bus_a.expected),  32'(m_pred));
        check("sat_locked",    32'(bus_b.locked),    32'(m_mode == 2));
        check("sat_error",     32'(bus_b.error),     32'(m_err));
        check("sat_err_count", 32'(bus_b.err_count), 32'(m_errc2));
        check("sat_expected",  32'(bus_b.expected),  32'(m_pred));
    endtask

    task automatic send_good();
        step(1'b0, 1'b1, g);
        g = ref_f(g);
    endtask

    task automatic send_bad(input logic [7:0] mask);
        step(1'b0, 1'b1, g ^ mask);
        g = ref_f(g);
    endtask

    task automatic clean_lock_from_01(input string tag);
        g = 8'h01;
        for (int i = 0; i < 5; i++) begin
            send_good();
            if (i == 0) check({tag, "_f01"}, 32'(bus_a.expected), 32'h1C);
            if (i == 1) check({tag, "_f1c"}, 32'(bus_a.expected), 32'h4B);
            if (i == 3) check({tag, "_not_yet"}, 32'(bus_a.locked), 32'd0);
        end
        check({tag, "_lock5"}, 32'(bus_a.locked), 32'd1);
    endtask

    initial begin
        logic [7:0] x;
        int r;
        Rst = 1'b1;
        bus_a.update = 1'b0; bus_a.data = 8'h00;
        bus_b.update = 1'b0; bus_b.data = 8'h00;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("rst_locked",   32'(bus_a.locked),    32'd0);
        check("rst_errcnt",   32'(bus_a.err_count), 32'd0);
        check("rst_expected", 32'(bus_a.expected),  32'h00);

        clean_lock_from_01("clean");
        check("clean_errcnt", 32'(bus_a.err_count), 32'd0);

        repeat (3) send_good();
        send_bad(8'h01);
        check("bit_err_pulse", 32'(bus_a.error),     32'd1);
        check("bit_err_cnt",   32'(bus_a.err_count), 32'd1);
        check("bit_err_lock",  32'(bus_a.locked),    32'd1);
        send_good();
        check("bit_err_next",  32'(bus_a.error),     32'd0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 8'($urandom));
            else send_good();
        end
        check("gap_errcnt", 32'(bus_a.err_count), 32'd1);

        for (int i = 0; i < 4; i++) send_bad(8'($urandom_range(1, 255)));
        check("loss_locked", 32'(bus_a.locked),    32'd0);
        check("loss_errcnt", 32'(bus_a.err_count), 32'd5);

        repeat (3) step(1'b0, 1'b1, 8'h00);
        check("zero_search", 32'(bus_a.locked), 32'd0);
        clean_lock_from_01("relock");
        check("relock_errcnt", 32'(bus_a.err_count), 32'd5);

        for (int i = 0; i < 10; i++) begin
            send_bad(8'h01 << $urandom_range(0, 7));
            send_good();
        end
        check("sat_hold",     32'(bus_b.err_count), 32'd3);
        check("sat_lock",     32'(bus_b.locked),    32'd1);
        check("sat_main_cnt", 32'(bus_a.err_count), 32'd15);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 11);
            case (r)
                0: step(1'b0, 1'b0, 8'($urandom));
                1: step(1'b0, 1'b1, 8'h00);
                2: send_bad(8'($urandom_range(1, 255)));
                3: begin
                    x = 8'($urandom);
                    step(1'b0, 1'b1, x);
                    g = ref_f(x);
                end
                default: send_good();
            endcase
        end

        step(1'b1, 1'b1, g);
        check("rstupd_locked",   32'(bus_a.locked),    32'd0);
        check("rstupd_errcnt",   32'(bus_a.err_count), 32'd0);
        check("rstupd_expected", 32'(bus_a.expected),  32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/prng8check.md
# prng8check

Receive-side checker for the parallel 8-bit PRNG byte stream. Takes one byte per `update` strobe, self-synchronises to the generator sequence, and then checks every following byte against its own locally predicted value. Reports lock status, single-cycle error strobes and a saturating error count. It sits at the far end of a link or loopback, paired with the parallel PRNG generator, for link BER testing.

## Interface
Parameters:
- `LOCK_CNT`, 4: consecutive correct predictions needed to declare lock (≥1).
- `LOSS_CNT`, 4: consecutive mismatches while locked that drop lock (≥1).
- `CNT_W`, 16: width of the error counter.

Ports:
- `clk`  input  1  clock; all logic on the rising edge.
- `Rst`  input  1  synchronous, active-high reset.
- `update`  input  1  `data` is valid this cycle.
- `data`  input  8  received PRNG byte.
- `locked`  output  1  checker is synchronised.
- `error`  output  1  one-cycle pulse: a locked-state byte mismatched.
- `err_count`  output  CNT_W  mismatches seen while locked; saturates at all-ones.
- `expected`  output  8  predicted value of the next byte.

## Operation
- Step function `F(x)` advances an 8-bit Fibonacci LFSR 8 single steps.
  - One step: `fb = s[7]^s[5]^s[4]^s[3]`; `s' = {s[6:0], fb}`.
  - The polynomial is x^8+x^6+x^5+x^4+1.
  - `F` is purely combinational. It must produce byte-identical results to the generator: F(0x01)=0x1C, F(0x1C)=0x4B.
- States: SEARCH, VERIFY, LOCKED. Internal counters are `match_cnt` and `bad_cnt`.
- SEARCH, on `update`:
  - `data`≠0: `expected`←F(data), `match_cnt`←0, go to VERIFY.
  - `data`=0: the all-zero byte is an illegal seed; ignore it and stay in SEARCH.
- VERIFY, on `update`:
  - Match: `expected`←F(data), `match_cnt`++. When `match_cnt` reaches LOCK_CNT, go to LOCKED with `bad_cnt`←0.
  - Mismatch, `data`≠0: reseed with `expected`←F(data), `match_cnt`←0, stay in VERIFY.
  - Mismatch, `data`=0: go to SEARCH.
  - Errors are not counted in this state.
- LOCKED, on `update`:
  - Always free-run the prediction: `expected`←F(expected). Never reseed from `data`, so a single bit error cannot propagate.
  - Match: `bad_cnt`←0.
  - Mismatch: `error` pulses, `err_count` increments with saturation, `bad_cnt`++.
  - When `bad_cnt` reaches LOSS_CNT, go to SEARCH. `locked` falls with the same edge, and `err_count` keeps its value.
- No `update`: state, counters and `expected` hold, and `error` is 0.
- `locked` is 1 exactly when the state is LOCKED.

## Timing
- All outputs are registered. `error`, `err_count`, `locked` and `expected` reflect an `update` byte on the first edge after it is sampled, i.e. 1-cycle latency.
- `update` may be high on every cycle (full rate). Back-to-back bytes need no bubbles.
- Reset values: state SEARCH, `locked`=0, `error`=0, `err_count`=0, `expected`=0x00, `match_cnt`=0, `bad_cnt`=0.
- `Rst` wins over `update` in the same cycle. A reset mid-lock returns to SEARCH on the next edge and clears `err_count`.
- Lock edge: the LOCK_CNT-th consecutive matching `update` sets `locked` on that same edge. The earliest lock is LOCK_CNT+1 updates after leaving reset.
- Loss edge: the LOSS_CNT-th consecutive mismatching `update` asserts `error` and clears `locked` on that same edge.
- Saturation: at `err_count`=2^CNT_W−1, further mismatches still pulse `error`, and the count holds.

## Test plan
- Clean lock. After reset, drive 0x01, 0x1C, 0x4B, then the next two model-generated bytes, with `update` held high. Required: `locked` rises after the 5th byte, `error` never pulses, `err_count`=0.
- Zero rejection. In SEARCH, drive 0x00 three times, then a clean sequence from 0x01. Required: stays in SEARCH through the zeros, then locks exactly 5 updates after 0x01.
- Single-bit error. Once locked, flip bit 0 of one byte. Required: exactly one `error` pulse, `err_count`=1, `locked` stays 1, the next byte matches with no further errors, and the prediction is not corrupted.
- Loss of lock. Once locked, drive 4 consecutive wrong bytes. Required: 4 `error` pulses, `err_count`=4, `locked`=0 after the 4th; a later clean sequence relocks and `err_count` stays 4.
- Gapped updates and reset. Insert random `update`=0 gaps while locked. Required: `expected` holds across the gaps and no errors are reported. Then assert `Rst` together with `update`. Required: next cycle `locked`=0, `err_count`=0, `expected`=0x00.
- Saturation, with CNT_W=2. Locked stream with every other byte corrupted. Required: `err_count` reaches 3 and holds, `error` keeps pulsing on each corrupted byte, and lock is not lost because `bad_cnt` never reaches LOSS_CNT.
